aes_key_expander: RTL

AES-128 key schedule generator that sits directly upstream of the unrolled pipelined encrypt core. It takes a 128-bit cipher key and iteratively produces all eleven round keys, one per clock cycle. The keys are delivered as a flat bus whose layout matches the encrypt core's `round_keys_flat` input. A ready flag tells the control logic when the flat bus is stable and plaintext may be issued.

---
 rtl/aes_key_expander.sv | 139 +++++++++++++
 1 files changed

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: one round key per enabled clock, exposed as a flat bus.
// Build option AES_KEYEXP_ZEROIZE_EN clears rk[1..NR] whenever a new key is accepted.
module aes_key_expander #(
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sys_en,
  input  logic                  key_load,
  input  logic [127:0]          cipher_key,
  output logic                  busy,
  output logic                  keys_ready,
  output logic [(NR+1)*128-1:0] round_keys_flat
);

  localparam int CNT_W = $clog2(NR + 2);

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         rcon_q, rcon_d;
  logic [127:0]       rk_q [NR+1];
  logic [127:0]       rk_d [NR+1];
  logic               accept;
  logic [127:0]       prev_key;
  logic [31:0]        temp, w0, w1, w2, w3;

  if (NR != 10) begin : g_nr_check
    $error("aes_key_expander supports only NR == 10");
  end

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign accept = sys_en && key_load && (state_q != ST_EXPAND);

  // Round function on rk[cnt-1]; counter is 1..NR while expanding.
  always_comb begin
    prev_key = '0;
    for (int k = 0; k < NR; k++) begin
      if (cnt_q == CNT_W'(k + 1)) prev_key = rk_q[k];
    end
    temp = sub_word({prev_key[23:0], prev_key[31:24]}) ^ {rcon_q, 24'h0};
    w0   = prev_key[127:96] ^ temp;
    w1   = prev_key[95:64]  ^ w0;
    w2   = prev_key[63:32]  ^ w1;
    w3   = prev_key[31:0]   ^ w2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sys_en) begin
      case (state_q)
        ST_IDLE,
        ST_READY:  if (key_load) state_d = ST_EXPAND;
        ST_EXPAND: if (cnt_q == CNT_W'(NR)) state_d = ST_READY;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = 1'b0;
    keys_ready = 1'b0;
    case (state_q)
      ST_EXPAND: busy       = 1'b1;
      ST_READY:  keys_ready = 1'b1;
      default:   ;
    endcase
  end

  always_comb begin
    rk_d   = rk_q;
    cnt_d  = cnt_q;
    rcon_d = rcon_q;
    if (accept) begin
      rk_d[0] = cipher_key;
`ifdef AES_KEYEXP_ZEROIZE_EN
      for (int k = 1; k <= NR; k++) rk_d[k] = '0;
`endif
      cnt_d  = CNT_W'(1);
      rcon_d = 8'h01;
    end else if (sys_en && (state_q == ST_EXPAND)) begin
      for (int k = 1; k <= NR; k++) begin
        if (cnt_q == CNT_W'(k)) rk_d[k] = {w0, w1, w2, w3};
      end
      rcon_d = xtime(rcon_q);
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rcon_q <= 8'h01;
      for (int k = 0; k <= NR; k++) rk_q[k] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rcon_q <= rcon_d;
      for (int k = 0; k <= NR; k++) rk_q[k] <= rk_d[k];
    end
  end

  for (genvar g = 0; g <= NR; g++) begin : g_flat
    assign round_keys_flat[g*128 +: 128] = rk_q[g];
  end

endmodule
